// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, typedefs and constants for the register file with write scoreboard
package regfile_pkg;
    localparam int BIT_WIDTH = 32;
    localparam int REG_WIDTH = 4;
    localparam int CNT_WIDTH = 2;
    localparam int REG_SIZE  = 1 << REG_WIDTH;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
    typedef logic [REG_WIDTH-1:0] reg_addr_t;
    typedef logic [BIT_WIDTH-1:0] reg_data_t;
    typedef logic [CNT_WIDTH-1:0] pend_cnt_t;
endpackage

// File: rtl/regfile_pend_cnt.sv
// regfile_pend_cnt: per-register in-flight write counter with saturation flag and underflow detect
module regfile_pend_cnt
    import regfile_pkg::*;
#(
    parameter int CNT_WIDTH = regfile_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_max,
    output logic                 underflow
);
    logic [CNT_WIDTH-1:0] cnt_nxt;

    assign at_max    = count == {CNT_WIDTH{1'b1}};
    assign underflow = dec && !inc && count == '0;

    // issue and retire on the same register cancel; a retire at zero holds zero
    always_comb
        cnt_nxt = flush ? '0 :
                  (inc && !dec) ? count + 1'b1 :
                  (dec && !inc && count != '0) ? count - 1'b1 : count;

    // count register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else        count <= cnt_nxt;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: N-read/1-write register file with write bypass and pending-write scoreboard
// Optional feature: define REGFILE_ZERO_REG_EN to make register 0 a constant zero that never counts.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int BIT_WIDTH = regfile_pkg::BIT_WIDTH,
    parameter int REG_WIDTH = regfile_pkg::REG_WIDTH,
    parameter int NUM_RD    = 2,
    parameter int CNT_WIDTH = regfile_pkg::CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wrt_en,
    input  logic [REG_WIDTH-1:0]          dr,
    input  logic [BIT_WIDTH-1:0]          d_in,
    input  logic [NUM_RD*REG_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*BIT_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic                          iss_en,
    input  logic [REG_WIDTH-1:0]          iss_dr,
    output logic                          iss_ready,
    input  logic                          flush,
    output logic                          sb_err
);
    localparam int RSIZE = 1 << REG_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [BIT_WIDTH-1:0] regs [RSIZE];
    logic [CNT_WIDTH-1:0] cnt  [RSIZE];
    logic [RSIZE-1:0]     inc_v, dec_v, at_max, underflow;
    logic                 wr_ok;

    assign wr_ok     = wrt_en && !(ZERO_REG && dr == '0);
    assign iss_ready = !at_max[iss_dr] || (wrt_en && dr == iss_dr) || (ZERO_REG && iss_dr == '0);

    for (genvar r = 0; r < RSIZE; r++) begin : g_cnt
        if (ZERO_REG && r == 0) begin : g_zero
            assign inc_v[r] = 1'b0;
            assign dec_v[r] = 1'b0;
        end else begin : g_norm
            assign inc_v[r] = iss_en && iss_ready && iss_dr == REG_WIDTH'(r);
            assign dec_v[r] = wrt_en && dr == REG_WIDTH'(r);
        end
        regfile_pend_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_v[r]),
            .dec       (dec_v[r]),
            .flush     (flush),
            .count     (cnt[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_WIDTH-1:0] a;
        logic                 byp;
        assign a   = rd_addr[i*REG_WIDTH +: REG_WIDTH];
        assign byp = wr_ok && dr == a;
        assign rd_data[i*BIT_WIDTH +: BIT_WIDTH] = (ZERO_REG && a == '0) ? '0 : byp ? d_in : regs[a];
        assign rd_busy[i] = cnt[a] > CNT_WIDTH'(1) || (cnt[a] == CNT_WIDTH'(1) && !byp);
    end

    // data array: writeback lands at the clock edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int r = 0; r < RSIZE; r++) regs[r] <= '0;
        else if (wr_ok) regs[dr] <= d_in;

    // sticky error for any retire of a register with nothing in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sb_err <= 1'b0;
        else        sb_err <= sb_err || (|underflow);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of read bypass, scoreboard counts, flush, reset and sb_err
module tb_regfile_scoreboard;
    localparam int BW = 32;
    localparam int RW = 4;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wrt_en;
    logic [RW-1:0]   dr;
    logic [BW-1:0]   d_in;
    logic [NR*RW-1:0] rd_addr;
    logic [NR*BW-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            iss_en;
    logic [RW-1:0]   iss_dr;
    logic            iss_ready;
    logic            flush;
    logic            sb_err;
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [BW-1:0]   exp_r0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_RD(NR), .CNT_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt_en    (wrt_en),
        .dr        (dr),
        .d_in      (d_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_en    (iss_en),
        .iss_dr    (iss_dr),
        .iss_ready (iss_ready),
        .flush     (flush),
        .sb_err    (sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [RW-1:0] a0, input logic [RW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wrt_en = 0; dr = '0; d_in = '0; rd_addr = '0;
        iss_en = 0; iss_dr = '0; flush = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // 1: reset state on every register
        for (int a = 0; a < 16; a++) begin
            iss_dr = RW'(a);
            rd(RW'(a), RW'(15 - a));
            chk("t1_data", rd_data, 64'h0);
            chk("t1_busy", rd_busy, 2'b00);
            chk("t1_ready", iss_ready, 1'b1);
        end
        chk("t1_sb_err", sb_err, 1'b0);
        // 2: write r5 with same-cycle bypass, then registered read
        iss_en = 1; iss_dr = 5; #1;
        chk("t2_iss_ready", iss_ready, 1'b1);
        tick(); iss_en = 0;
        rd(5, 5);
        chk("t2_busy_pend", rd_busy, 2'b11);
        wrt_en = 1; dr = 5; d_in = 32'hDEADBEEF; #1;
        chk("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
        chk("t2_busy_byp", rd_busy, 2'b00);
        tick(); wrt_en = 0; #1;
        chk("t2_reg", rd_data[31:0], 32'hDEADBEEF);
        chk("t2_busy_after", rd_busy, 2'b00);
        chk("t2_sb_err", sb_err, 1'b0);
        // 3: saturate r3 at three issues, fourth ignored
        iss_en = 1; iss_dr = 3;
        for (int k = 0; k < 3; k++) begin
            #1; chk("t3_ready_n", iss_ready, 1'b1);
            tick();
        end
        rd(3, 3);
        chk("t3_busy", rd_busy, 2'b11);
        chk("t3_full", iss_ready, 1'b0);
        tick(); iss_en = 0;
        wrt_en = 1; dr = 3; d_in = 32'h33; #1;
        chk("t3_ready_byp", iss_ready, 1'b1);
        chk("t3_busy_c3", rd_busy, 2'b11);
        tick(); #1;
        chk("t3_busy_c2", rd_busy, 2'b11);
        wrt_en = 0; #1;
        chk("t3_ready_c2", iss_ready, 1'b1);
        wrt_en = 1; tick(); #1;
        chk("t3_busy_last", rd_busy, 2'b00);
        tick(); wrt_en = 0; #1;
        chk("t3_busy_done", rd_busy, 2'b00);
        chk("t3_data", rd_data, {32'h33, 32'h33});
        chk("t3_sb_err", sb_err, 1'b0);
        // 4: retire last write on r7 with bypass, then issue+retire at zero
        iss_en = 1; iss_dr = 7; tick(); iss_en = 0;
        rd(7, 7);
        wrt_en = 1; dr = 7; d_in = 32'h11; #1;
        chk("t4_busy1", rd_busy[1], 1'b0);
        chk("t4_data1", rd_data[63:32], 32'h11);
        tick();
        iss_en = 1; iss_dr = 7; d_in = 32'h22; #1;
        chk("t4_ready", iss_ready, 1'b1);
        tick(); iss_en = 0; wrt_en = 0; #1;
        chk("t4_busy_same", rd_busy, 2'b00);
        chk("t4_data_same", rd_data[31:0], 32'h22);
        chk("t4_sb_err", sb_err, 1'b0);
        // 5: flush pending marks, late writeback flags error
        iss_en = 1;
        iss_dr = 2; tick();
        iss_dr = 4; tick();
        iss_dr = 9; tick();
        iss_en = 0;
        rd(2, 9);
        chk("t5_busy_pre", rd_busy, 2'b11);
        flush = 1; tick(); flush = 0;
        rd(2, 9);
        chk("t5_busy_29", rd_busy, 2'b00);
        rd(4, 4);
        chk("t5_busy_4", rd_busy, 2'b00);
        wrt_en = 1; dr = 4; d_in = 32'h44; tick(); wrt_en = 0; #1;
        chk("t5_sb_err_set", sb_err, 1'b1);
        tick(); tick();
        chk("t5_sb_err_sticky", sb_err, 1'b1);
        // reset mid-operation drops pending marks and data
        iss_en = 1; iss_dr = 6; tick(); iss_en = 0;
        rd(5, 6);
        chk("t5_busy6", rd_busy, 2'b10);
        #2; rst_n = 1'b0; #1;
        chk("t5_rst_err", sb_err, 1'b0);
        chk("t5_rst_data", rd_data, 64'h0);
        chk("t5_rst_busy", rd_busy, 2'b00);
        tick(); rst_n = 1'b1; tick();
        wrt_en = 1; dr = 6; d_in = 32'h66; tick(); wrt_en = 0; #1;
        chk("t5_late_wb", sb_err, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        // 6: register 0 behaviour
`ifdef REGFILE_ZERO_REG_EN
        exp_r0 = 32'h0;
`else
        exp_r0 = 32'h5;
`endif
        iss_en = 1; iss_dr = 0; tick(); iss_en = 0;
        wrt_en = 1; dr = 0; d_in = 32'h5; tick(); wrt_en = 0;
        rd(0, 0);
        chk("t6_data", rd_data[31:0], exp_r0);
        chk("t6_busy", rd_busy, 2'b00);
        chk("t6_sb_err", sb_err, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
